// File: rtl/ps2_rx_frame.sv
// PS/2 keyboard receiver: pin synchronisation, clock glitch filter, 11-bit frame
// assembly with parity/stop checking, and E0/F0 prefix folding into key-event flags.
module ps2_rx_frame #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 6000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       is_break,
    output logic       is_extended,
    output logic       code_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Good frame: data plus parity bit has an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    logic [1:0]    clk_sync_r;
    logic [1:0]    data_sync_r;
    logic          filt_r;
    logic [4:0]    filt_cnt_r;
    logic          fall_s;
    logic          bit_s;
    state_t        state_r;
    logic [7:0]    shift_r;
    logic [2:0]    bit_cnt_r;
    logic          par_r;
    logic [TW-1:0] to_cnt_r;
    logic          ext_pend_r;
    logic          brk_pend_r;

    // Two-flop synchronisers for both pins; idle level is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_r  <= 2'b11;
            data_sync_r <= 2'b11;
        end else begin
            clk_sync_r  <= {clk_sync_r[0], ps2_clk};
            data_sync_r <= {data_sync_r[0], ps2_data};
        end
    end

    // Glitch filter: filtered clock follows only after FILTER_LEN agreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_r     <= 1'b1;
            filt_cnt_r <= 5'd0;
        end else if (clk_sync_r[1] == filt_r) begin
            filt_cnt_r <= 5'd0;
        end else if (filt_cnt_r == 5'(FILTER_LEN - 1)) begin
            filt_r     <= clk_sync_r[1];
            filt_cnt_r <= 5'd0;
        end else begin
            filt_cnt_r <= filt_cnt_r + 5'd1;
        end
    end

    // Fall strobe fires in the cycle the filtered clock commits to low.
    always_comb begin
        fall_s = 1'b0;
        if (filt_r && !clk_sync_r[1] && (filt_cnt_r == 5'(FILTER_LEN - 1))) begin
            fall_s = 1'b1;
        end else begin
            fall_s = 1'b0;
        end
    end

    assign bit_s = data_sync_r[1];

    // Frame FSM with registered outputs, timeout watchdog and prefix decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            shift_r     <= 8'h00;
            bit_cnt_r   <= 3'd0;
            par_r       <= 1'b0;
            to_cnt_r    <= '0;
            ext_pend_r  <= 1'b0;
            brk_pend_r  <= 1'b0;
            code        <= 8'h00;
            is_break    <= 1'b0;
            is_extended <= 1'b0;
            code_valid  <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if ((state_r != IDLE) && (to_cnt_r == TW'(TIMEOUT_CYCLES))) begin
                frame_err  <= 1'b1;
                ext_pend_r <= 1'b0;
                brk_pend_r <= 1'b0;
                to_cnt_r   <= '0;
                state_r    <= IDLE;
                busy       <= 1'b0;
            end else if (fall_s) begin
                to_cnt_r <= '0;
                case (state_r)
                    IDLE: begin
                        if (!bit_s) begin
                            state_r   <= DATA;
                            bit_cnt_r <= 3'd0;
                            busy      <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    DATA: begin
                        shift_r <= {bit_s, shift_r[7:1]};
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= PARITY;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end
                    PARITY: begin
                        par_r   <= bit_s;
                        state_r <= STOP;
                    end
                    STOP: begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        if (!odd_parity_ok(shift_r, par_r) || !bit_s) begin
                            parity_err <= !odd_parity_ok(shift_r, par_r);
                            frame_err  <= !bit_s;
                            ext_pend_r <= 1'b0;
                            brk_pend_r <= 1'b0;
                        end else if (shift_r == 8'hE0) begin
                            ext_pend_r <= 1'b1;
                        end else if (shift_r == 8'hF0) begin
                            brk_pend_r <= 1'b1;
                        end else begin
                            code        <= shift_r;
                            is_break    <= brk_pend_r;
                            is_extended <= ext_pend_r;
                            code_valid  <= 1'b1;
                            ext_pend_r  <= 1'b0;
                            brk_pend_r  <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end else if (state_r != IDLE) begin
                to_cnt_r <= to_cnt_r + TW'(1);
            end else begin
                to_cnt_r <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Self-checking bench for ps2_rx_frame: randomized frames against a queue-level
// scancode model, with scaled-down bit period and timeout to keep runs short.
module tb_ps2_rx_frame;

    localparam int FL = 4;
    localparam int TO = 300;
    localparam int H  = 25;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] code;
    logic       is_break, is_extended, code_valid, parity_err, frame_err, busy;

    ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .code(code), .is_break(is_break), .is_extended(is_extended),
        .code_valid(code_valid), .parity_err(parity_err), .frame_err(frame_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Observed events, written only by the monitor.
    logic [9:0] obs_mem [256];
    int obs_n = 0, obs_perr = 0, obs_ferr = 0;
    // Expected events, written only by the stimulus process.
    logic [9:0] exp_mem [256];
    int exp_n = 0, exp_perr = 0, exp_ferr = 0, chk = 0;
    bit m_ext = 1'b0, m_brk = 1'b0;

    always @(negedge clk) begin
        if (code_valid) begin
            if (obs_n < 256) obs_mem[obs_n] = {is_break, is_extended, code};
            obs_n = obs_n + 1;
        end
        if (parity_err) obs_perr = obs_perr + 1;
        if (frame_err)  obs_ferr = obs_ferr + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Keyboard-level model of what a received frame should produce.
    task automatic model_frame(input logic [7:0] d, input bit pflip, input bit stop_bad);
        if (pflip || stop_bad) begin
            if (pflip) exp_perr++;
            if (stop_bad) exp_ferr++;
            m_ext = 1'b0; m_brk = 1'b0;
        end else if (d == 8'hE0) begin
            m_ext = 1'b1;
        end else if (d == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            exp_mem[exp_n] = {m_brk, m_ext, d};
            exp_n++;
            m_ext = 1'b0; m_brk = 1'b0;
        end
    endtask

    // One PS/2 bit: data set while clock high, then a low phase; optional 1-cycle glitch.
    task automatic send_bit(input bit b, input bit glitch);
        int g;
        ps2_data = b;
        if (glitch && $urandom_range(0, 1) == 0) begin
            g = $urandom_range(10, H - 4);
            cyc(g); ps2_clk = 1'b0; cyc(1); ps2_clk = 1'b1; cyc(H - g - 1);
            ps2_clk = 1'b0; cyc(H);
        end else if (glitch) begin
            cyc(H); ps2_clk = 1'b0;
            g = $urandom_range(10, H - 4);
            cyc(g); ps2_clk = 1'b1; cyc(1); ps2_clk = 1'b0; cyc(H - g - 1);
        end else begin
            cyc(H); ps2_clk = 1'b0; cyc(H);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pflip, input bit stop_bad,
                              input bit glitch);
        logic p;
        p = ~(^d) ^ pflip;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
        send_bit(p, glitch);
        send_bit(~stop_bad, 1'b0);
        ps2_data = 1'b1;
        cyc(H);
        model_frame(d, pflip, stop_bad);
    endtask

    task automatic test_reset;
        reset = 1'b1; cyc(5); reset = 1'b0; cyc(1);
        n_cmp++; if (code !== 8'h00) begin n_bad++; $display("FAIL reset_code got %h want 00", code); end
        n_cmp++; if ({is_break, is_extended, code_valid, parity_err, frame_err, busy} !== 6'b0) begin
            n_bad++; $display("FAIL reset_flags got %b want 000000",
                {is_break, is_extended, code_valid, parity_err, frame_err, busy});
        end
    endtask

    task automatic test_basic;
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (obs_n !== 1) begin n_bad++; $display("FAIL basic_count got %0d want 1", obs_n); end
        n_cmp++; if (obs_mem[0] !== {2'b00, 8'h1C}) begin n_bad++; $display("FAIL basic_event got %h want %h", obs_mem[0], {2'b00, 8'h1C}); end
        n_cmp++; if (obs_perr + obs_ferr !== 0) begin n_bad++; $display("FAIL basic_err got %0d want 0", obs_perr + obs_ferr); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy got %b want 0", busy); end
        chk = exp_n;
    endtask

    task automatic test_prefix;
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h74, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (obs_n !== exp_n) begin n_bad++; $display("FAIL prefix_count got %0d want %0d", obs_n, exp_n); end
        for (int i = chk; i < exp_n && i < obs_n; i++) begin
            n_cmp++; if (obs_mem[i] !== exp_mem[i]) begin n_bad++; $display("FAIL prefix_event[%0d] got %h want %h", i, obs_mem[i], exp_mem[i]); end
        end
        chk = exp_n;
    endtask

    task automatic test_errors;
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (obs_perr !== exp_perr) begin n_bad++; $display("FAIL parity_err got %0d want %0d", obs_perr, exp_perr); end
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (obs_ferr !== exp_ferr) begin n_bad++; $display("FAIL stop_err got %0d want %0d", obs_ferr, exp_ferr); end
        n_cmp++; if (obs_n !== exp_n) begin n_bad++; $display("FAIL err_nocode got %0d want %0d", obs_n, exp_n); end
        send_frame(8'h23, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (obs_n !== exp_n || obs_mem[exp_n-1] !== exp_mem[exp_n-1]) begin
            n_bad++; $display("FAIL err_recover got %0d/%h want %0d/%h", obs_n, obs_mem[exp_n-1], exp_n, exp_mem[exp_n-1]);
        end
        chk = exp_n;
    endtask

    task automatic test_timeout;
        send_bit(1'b0, 1'b0);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL timeout_busy_hi got %b want 1", busy); end
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        ps2_data = 1'b1;
        cyc(TO + 10);
        exp_ferr++; m_ext = 1'b0; m_brk = 1'b0;
        n_cmp++; if (obs_ferr !== exp_ferr) begin n_bad++; $display("FAIL timeout_ferr got %0d want %0d", obs_ferr, exp_ferr); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL timeout_busy_lo got %b want 0", busy); end
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (obs_n !== exp_n || obs_mem[exp_n-1] !== exp_mem[exp_n-1]) begin
            n_bad++; $display("FAIL timeout_recover got %0d/%h want %0d/%h", obs_n, obs_mem[exp_n-1], exp_n, exp_mem[exp_n-1]);
        end
        chk = exp_n;
    endtask

    task automatic test_glitch;
        ps2_data = 1'b0;
        ps2_clk = 1'b0; cyc(FL - 1); ps2_clk = 1'b1;
        cyc(12);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_idle_busy got %b want 0", busy); end
        ps2_data = 1'b1; cyc(H);
        for (int k = 0; k < 6; k++) send_frame(8'($urandom_range(1, 8'hDF)), 1'b0, 1'b0, 1'b1);
        n_cmp++; if (obs_n !== exp_n) begin n_bad++; $display("FAIL glitch_count got %0d want %0d", obs_n, exp_n); end
        for (int i = chk; i < exp_n && i < obs_n; i++) begin
            n_cmp++; if (obs_mem[i] !== exp_mem[i]) begin n_bad++; $display("FAIL glitch_event[%0d] got %h want %h", i, obs_mem[i], exp_mem[i]); end
        end
        chk = exp_n;
    endtask

    task automatic test_random;
        logic [7:0] d;
        int r;
        for (int k = 0; k < 24; k++) begin
            r = $urandom_range(0, 9);
            d = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
            send_frame(d, ($urandom_range(0, 6) == 0), ($urandom_range(0, 7) == 0), 1'b0);
            n_cmp++; if (obs_n !== exp_n || obs_perr !== exp_perr || obs_ferr !== exp_ferr) begin
                n_bad++; $display("FAIL random_counts[%0d] got %0d/%0d/%0d want %0d/%0d/%0d", k,
                    obs_n, obs_perr, obs_ferr, exp_n, exp_perr, exp_ferr);
            end
            for (int i = chk; i < exp_n && i < obs_n; i++) begin
                n_cmp++; if (obs_mem[i] !== exp_mem[i]) begin n_bad++; $display("FAIL random_event[%0d] got %h want %h", i, obs_mem[i], exp_mem[i]); end
            end
            chk = exp_n;
        end
    endtask

    task automatic test_reset_midframe;
        int n0, pe0, fe0;
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        n0 = obs_n; pe0 = obs_perr; fe0 = obs_ferr;
        reset = 1'b1; cyc(2); reset = 1'b0; cyc(1);
        m_ext = 1'b0; m_brk = 1'b0;
        n_cmp++; if ({code, is_break, is_extended, code_valid, parity_err, frame_err, busy} !== 14'b0) begin
            n_bad++; $display("FAIL midreset_outputs got %h/%b want 00/000000", code,
                {is_break, is_extended, code_valid, parity_err, frame_err, busy});
        end
        cyc(TO + 10);
        n_cmp++; if (obs_n !== n0 || obs_perr !== pe0 || obs_ferr !== fe0) begin
            n_bad++; $display("FAIL midreset_pulses got %0d/%0d/%0d want %0d/%0d/%0d",
                obs_n, obs_perr, obs_ferr, n0, pe0, fe0);
        end
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (obs_n !== exp_n || obs_mem[exp_n-1] !== exp_mem[exp_n-1]) begin
            n_bad++; $display("FAIL midreset_recover got %0d/%h want %0d/%h", obs_n, obs_mem[exp_n-1], exp_n, exp_mem[exp_n-1]);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_prefix;
        test_errors;
        test_timeout;
        test_glitch;
        test_random;
        test_reset_midframe;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
